// File: rtl/mod_cu.sv
// Control FSM for the repeated-subtraction modulus datapath: LOAD, then one SUB per subtraction, then a DONE/ERR pulse.
// Start is accepted only in IDLE. MOD_CU_ITER_LIMIT_EN adds an abort after MAX_ITER subtractions.
module mod_cu #(
  parameter int CNT_W    = 32,
  parameter int MAX_ITER = 1024
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      b,
  input  logic             x,
  output logic             s,
  output logic             we,
  output logic             busy,
  output logic             done,
  output logic             err_div0,
  output logic             err_timeout,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SUB  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] iter_inc;
  logic             b_zero;
  logic             limit_hit;
  logic             err_to;

  assign iter_inc = iter_count + CNT_W'(1);
  assign b_zero   = (b == 32'd0);

  // limit_hit compares against the count after this cycle's subtraction
`ifdef MOD_CU_ITER_LIMIT_EN
  assign limit_hit = (iter_inc == CNT_W'(MAX_ITER));
`else
  assign limit_hit = 1'b0 & (iter_inc == CNT_W'(MAX_ITER));
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      iter_count <= '0;
      err_to     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == LOAD)
        iter_count <= '0;
      else if (state == SUB)
        iter_count <= iter_inc;
      if (state_nxt == ERR)
        err_to <= (state == SUB);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        // a zero divisor must never reach SUB: x would never rise
        if (b_zero)   state_nxt = ERR;
        else if (x)   state_nxt = DONE;
        else          state_nxt = SUB;
      end
      SUB: begin
        if (x)              state_nxt = DONE;
        else if (limit_hit) state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign s        = (state == SUB);
  assign we       = (state == LOAD) || (state == SUB);
  assign busy     = (state == LOAD) || (state == SUB);
  assign done     = (state == DONE) || (state == ERR);
  assign err_div0 = (state == ERR) && !err_to;

`ifdef MOD_CU_ITER_LIMIT_EN
  assign err_timeout = (state == ERR) && err_to;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mod_cu.sv
// Bench for mod_cu with a behavioural repeated-subtraction datapath alongside it.
module tb_mod_cu;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        x;
  logic        s;
  logic        we;
  logic        busy;
  logic        done;
  logic        err_div0;
  logic        err_timeout;
  logic [31:0] iter_count;

  logic [31:0] dp_result;
  logic [31:0] sum;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mod_cu #(.CNT_W(32), .MAX_ITER(4)) dut (
    .CLK(CLK), .reset(reset), .start(start), .b(b), .x(x),
    .s(s), .we(we), .busy(busy), .done(done),
    .err_div0(err_div0), .err_timeout(err_timeout), .iter_count(iter_count)
  );

  // datapath: select a or dpResult-b, flag when the selected sum is below b
  assign sum = s ? (dp_result - b) : a;
  assign x   = (sum < b);
  always_ff @(posedge CLK) if (we) dp_result <= sum;

  // run results captured in the done cycle and the cycle after it
  int          r_cycles, r_we, r_sub;
  bit          r_timeout;
  logic        r_div0, r_tout, r_post_busy, r_post_done;
  logic [31:0] r_dp, r_iter;

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int limit);
    @(negedge CLK);
    a = av; b = bv; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    r_cycles = 1; r_we = 0; r_sub = 0; r_timeout = 1'b0;
    while (!done && r_cycles < limit) begin
      if (we) r_we++;
      if (busy && s) r_sub++;
      @(posedge CLK); #1;
      r_cycles++;
    end
    r_timeout = !done;
    r_dp = dp_result; r_iter = iter_count;
    r_div0 = err_div0; r_tout = err_timeout;
    @(posedge CLK); #1;
    r_post_busy = busy; r_post_done = done;
  endtask

  task automatic test_reset;
    start = 1'b0; a = '0; b = '0; reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({s, we, busy, done, err_div0, err_timeout} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=000000", {s, we, busy, done, err_div0, err_timeout});
    end
    checks++;
    if (iter_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_iter got=%0d want=0", iter_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    run_op(32'd17, 32'd5, 200);
    checks++;
    if (r_timeout || r_cycles != 5) begin
      failures++;
      $display("FAIL basic_latency got=%0d timeout=%0b want=5", r_cycles, r_timeout);
    end
    checks++;
    if (r_dp !== 32'd2 || r_iter !== 32'd3) begin
      failures++;
      $display("FAIL basic_result got dp=%0d iter=%0d want dp=2 iter=3", r_dp, r_iter);
    end
    checks++;
    if (r_sub != 3 || r_div0 !== 1'b0 || r_tout !== 1'b0) begin
      failures++;
      $display("FAIL basic_subs_errs got sub=%0d div0=%b tout=%b want 3 0 0", r_sub, r_div0, r_tout);
    end
  endtask

  task automatic test_a_lt_b;
    run_op(32'd3, 32'd5, 200);
    checks++;
    if (r_timeout || r_cycles != 2 || r_we != 1 || r_sub != 0) begin
      failures++;
      $display("FAIL altb_timing got cyc=%0d we=%0d sub=%0d want 2 1 0", r_cycles, r_we, r_sub);
    end
    checks++;
    if (r_dp !== 32'd3 || r_iter !== 32'd0) begin
      failures++;
      $display("FAIL altb_result got dp=%0d iter=%0d want dp=3 iter=0", r_dp, r_iter);
    end
  endtask

  task automatic test_a_eq_b;
    run_op(32'd5, 32'd5, 200);
    checks++;
    if (r_timeout || r_cycles != 3 || r_dp !== 32'd0 || r_iter !== 32'd1) begin
      failures++;
      $display("FAIL aeqb got cyc=%0d dp=%0d iter=%0d want 3 0 1", r_cycles, r_dp, r_iter);
    end
  endtask

  task automatic test_div0;
    run_op(32'd9, 32'd0, 200);
    checks++;
    if (r_timeout || r_cycles != 2 || r_div0 !== 1'b1 || r_tout !== 1'b0) begin
      failures++;
      $display("FAIL div0_err got cyc=%0d div0=%b tout=%b want 2 1 0", r_cycles, r_div0, r_tout);
    end
    checks++;
    if (r_sub != 0 || r_post_busy !== 1'b0 || r_post_done !== 1'b0) begin
      failures++;
      $display("FAIL div0_after got sub=%0d busy=%b done=%b want 0 0 0", r_sub, r_post_busy, r_post_done);
    end
  endtask

  task automatic test_reset_mid_op;
    int subs;
    subs = 0;
    @(negedge CLK);
    a = 32'd1000; b = 32'd1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && subs < 3; i++) begin
      @(posedge CLK); #1;
      if (busy && s) subs++;
      if (subs == 2 && start == 1'b0) start = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (!(busy && s) || iter_count !== 32'd2) begin
      failures++;
      $display("FAIL midop_sub3 got busy=%b s=%b iter=%0d want 1 1 2", busy, s, iter_count);
    end
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
    checks++;
    if (we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || iter_count !== 32'd0) begin
      failures++;
      $display("FAIL midop_reset got we=%b busy=%b done=%b iter=%0d want 0 0 0 0", we, busy, done, iter_count);
    end
    run_op(32'd7, 32'd2, 200);
    checks++;
    if (r_timeout || r_cycles != 5 || r_dp !== 32'd1 || r_iter !== 32'd3) begin
      failures++;
      $display("FAIL midop_rerun got cyc=%0d dp=%0d iter=%0d want 5 1 3", r_cycles, r_dp, r_iter);
    end
  endtask

  task automatic test_back_to_back;
    run_op(32'd10, 32'd4, 200);
    checks++;
    if (r_timeout || r_dp !== 32'd2 || r_iter !== 32'd2) begin
      failures++;
      $display("FAIL b2b_first got dp=%0d iter=%0d want dp=2 iter=2", r_dp, r_iter);
    end
    run_op(32'd4, 32'd10, 200);
    checks++;
    if (r_timeout || r_cycles != 2 || r_dp !== 32'd4 || r_iter !== 32'd0) begin
      failures++;
      $display("FAIL b2b_second got cyc=%0d dp=%0d iter=%0d want 2 4 0", r_cycles, r_dp, r_iter);
    end
  endtask

  task automatic test_iter_limit;
    run_op(32'd100, 32'd1, 2000);
`ifdef MOD_CU_ITER_LIMIT_EN
    checks++;
    if (r_timeout || r_sub != 4 || r_tout !== 1'b1 || r_div0 !== 1'b0 || r_iter !== 32'd4) begin
      failures++;
      $display("FAIL limit_on got sub=%0d tout=%b div0=%b iter=%0d want 4 1 0 4", r_sub, r_tout, r_div0, r_iter);
    end
`else
    checks++;
    if (r_timeout || r_sub != 100 || r_cycles != 102 || r_tout !== 1'b0) begin
      failures++;
      $display("FAIL limit_off_timing got sub=%0d cyc=%0d tout=%b want 100 102 0", r_sub, r_cycles, r_tout);
    end
    checks++;
    if (r_dp !== 32'd0 || r_iter !== 32'd100) begin
      failures++;
      $display("FAIL limit_off_result got dp=%0d iter=%0d want 0 100", r_dp, r_iter);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_a_lt_b;
    test_a_eq_b;
    test_div0;
    test_reset_mid_op;
    test_back_to_back;
    test_iter_limit;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
